relu_maxpool: RTL and testbench
===============================

Name: relu_maxpool

Overview:
- Streaming ReLU + 2x2/stride-2 max-pooling stage directly downstream of the multi-kernel convolution engine.
- Consumes one raster-ordered conv output beat per valid cycle, all nok kernel channels in parallel.
- Emits one pooled beat per completed 2x2 window, all channels in parallel, with a pooled index and a sticky finish flag.
- Output feeds the next conv layer's input buffer or the host writeback.

Parameters:
- N, 7, input pixel MSB; conv sample width is W = 2*N+2 bits, signed two's complement.
- nok, 3, number of parallel kernel channels.
- MAXW, 32, maximum conv output row length; line buffer depth is MAXW/2 per channel.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- in_data, input, nok x W, conv outputs for one pixel position, channel k on in_data[k].
- in_valid, input, 1, in_data qualifier sampled on posedge clk; one beat per cycle max.
- conv_fin, input, 1, level from the conv engine: all conv outputs delivered.
- row_len, input, 12, conv output row length, valid range 2..MAXW; latched on the first accepted beat of a frame.
- relu_en, input, 1, 1 = clamp negatives to 0 before pooling; 0 = pool signed raw values.
- out_data, output, nok x W, pooled result per channel, signed.
- out_valid, output, 1, one-cycle pulse per pooled beat.
- out_idx, output, 12, raster index of the pooled beat, 0-based, increments per out_valid.
- pool_fin, output, 1, sticky frame-complete flag.

Behaviour:
- Reset (reset=0, async): out_data=0, out_valid=0, out_idx=0, pool_fin=0, col=0, row=0, state=IDLE; line buffer contents don't-care.
- States:
  - IDLE: waits for in_valid or conv_fin. The first in_valid latches row_len into len_r, processes that beat, and moves to RUN. conv_fin=1 in IDLE with no beats moves to DONE.
  - RUN: processes beats. A conv_fin rising edge moves to DONE on the next cycle, after any same-cycle beat is processed.
  - DONE: pool_fin=1 and held; in_valid is ignored; leaves only via reset.
- Per-channel ReLU: v = (relu_en && in_data[k] < 0) ? 0 : in_data[k]. The comparison is signed on W bits; width is unchanged, no saturation.
- Column/row tracking:
  - col counts 0..len_r-1 per accepted beat, then wraps to 0 and toggles row parity.
  - Even col: v is latched into hold[k].
  - Odd col: pm = max(hold[k], v).
- Even row, odd col: pm is written to linebuf[k][col>>1].
- Odd row, odd col: out_data[k] <= max(linebuf[k][col>>1], pm), out_valid <= 1 next cycle, out_idx advances after that beat.
- Latency: out_valid asserts exactly 1 cycle after the in_valid beat completing the window (odd row, odd col).
- Odd len_r: the last column is consumed but not pooled (floor semantics); the buffer write is skipped.
- Odd row count at conv_fin: the last even row's partial maxima are discarded and no output is produced.
- len_r > MAXW: columns >= MAXW are counted but produce no buffer write or output. len_r < 2: no outputs are emitted; pool_fin still asserts.
- Max ties: either operand may be chosen (values are equal). Gaps in in_valid are allowed anywhere and state is held.
- in_valid and the conv_fin rise in the same cycle: the beat is processed, and pool_fin asserts 2 cycles after that edge, one cycle after its out_valid if any.
- Reset asserted mid-frame: all state clears immediately; the next beat starts a new frame with a fresh row_len latch.
- out_idx is 12 bits and wraps naturally; the maximum reachable value is (MAXW/2)^2-1.

Test Plan:
- nok=3, row_len=4, relu_en=1, stream 16 beats with ch0 = 0..15 → 4 out_valid pulses; ch0 outputs 5, 7, 13, 15; out_idx 0..3; pool_fin 2 cycles after the conv_fin rise.
- relu_en=1, ch2 stream all -5 over a 4x4 frame → every ch2 output is 0. Same stream with relu_en=0 → every ch2 output is -5 (16'hFFFB).
- row_len=5, 5x5 frame with ch1 = index value → 4 outputs: 6, 8, 16, 18. Column 4 and row 4 are dropped; exactly 4 pulses.
- row_len=28, in_valid toggled 1-0-1 randomly, 28x28 frame with channels matching a golden model → 196 outputs, out_idx ending at 195, values bit-exact to the model.
- Reset low for 2 cycles after 10 beats of a 4x4 frame, then a full 4x4 frame → no stale output; exactly 4 pulses with correct maxima; out_idx restarts at 0.
- conv_fin=1 in IDLE with no beats → pool_fin=1 two cycles later, no out_valid; later in_valid is ignored.

Source files
------------

// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling over raster-ordered conv output.
// All kernel channels are processed in parallel; one pooled beat per completed window.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame (or conv_fin with no beats)
// RUN   | consuming beats, pooling windows as they complete
// DONE  | frame complete, pool_fin held, beats ignored until reset
module relu_maxpool #(
    parameter  int N    = 7,
    parameter  int nok  = 3,
    parameter  int MAXW = 32,
    localparam int W    = 2*N+2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [nok-1:0][W-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   conv_fin,
    input  logic [11:0]            row_len,
    input  logic                   relu_en,
    output logic [nok-1:0][W-1:0]  out_data,
    output logic                   out_valid,
    output logic [11:0]            out_idx,
    output logic                   pool_fin
);

    localparam int HW = MAXW/2;
    localparam int AW = (HW > 1) ? $clog2(HW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [11:0]            len_r, col, eff_len;
    logic                   row_odd, conv_fin_q;
    logic [nok-1:0][W-1:0]  hold, v, pm, pool;
    logic [W-1:0]           linebuf [nok][HW];
    logic                   beat, last_col, in_range, col_odd;
    logic [AW-1:0]          lb_addr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid)      state_nxt = conv_fin ? DONE : RUN;
                else if (conv_fin) state_nxt = DONE;
            end
            RUN:     if (conv_fin && !conv_fin_q) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first beat of a frame uses row_len directly since len_r is only latched on it.
    always_comb begin
        beat     = in_valid && (state != DONE);
        eff_len  = (state == IDLE) ? row_len : len_r;
        last_col = (eff_len < 12'd2) || (col == eff_len - 12'd1);
        in_range = (col < 12'(MAXW));
        col_odd  = col[0] && in_range;
        lb_addr  = col[AW:1];
    end

    always_comb begin
        v    = '0;
        pm   = '0;
        pool = '0;
        for (int k = 0; k < nok; k++) begin
            v[k]    = (relu_en && in_data[k][W-1]) ? '0 : in_data[k];
            pm[k]   = ($signed(hold[k]) > $signed(v[k])) ? hold[k] : v[k];
            pool[k] = ($signed(linebuf[k][lb_addr]) > $signed(pm[k])) ? linebuf[k][lb_addr] : pm[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len_r      <= '0;
            col        <= '0;
            row_odd    <= 1'b0;
            conv_fin_q <= 1'b0;
            hold       <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            pool_fin   <= 1'b0;
        end else begin
            state      <= state_nxt;
            conv_fin_q <= conv_fin;
            pool_fin   <= (state == DONE);
            out_valid  <= 1'b0;
            if (out_valid) out_idx <= out_idx + 12'd1;
            if (beat) begin
                if (state == IDLE) len_r <= row_len;
                if (last_col) begin
                    col     <= '0;
                    row_odd <= ~row_odd;
                end else begin
                    col <= col + 12'd1;
                end
                if (!col[0]) hold <= v;
                if (col_odd && row_odd) begin
                    out_data  <= pool;
                    out_valid <= 1'b1;
                end
            end
        end
    end

    // Line buffer holds the even-row pair maxima; contents need no reset.
    always_ff @(posedge clk) begin
        if (beat && col_odd && !row_odd) begin
            for (int k = 0; k < nok; k++) linebuf[k][lb_addr] <= pm[k];
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool: stimulus pushes expected pooled beats,
// a negedge monitor pops and compares them whenever out_valid is seen.
module tb_relu_maxpool;

    localparam int N    = 7;
    localparam int NOK  = 3;
    localparam int W    = 2*N+2;
    localparam int MAXW = 32;

    typedef logic [NOK-1:0][W-1:0] beat_t;
    typedef struct {
        beat_t d;
        int    idx;
        int    cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    beat_t       in_data;
    logic        in_valid;
    logic        conv_fin;
    logic [11:0] row_len;
    logic        relu_en;
    beat_t       out_data;
    logic        out_valid;
    logic [11:0] out_idx;
    logic        pool_fin;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    relu_maxpool #(.N(N), .nok(NOK), .MAXW(MAXW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .conv_fin(conv_fin), .row_len(row_len), .relu_en(relu_en),
        .out_data(out_data), .out_valid(out_valid), .out_idx(out_idx),
        .pool_fin(pool_fin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pixv(input int mode, input int k, input int r, input int c, input int cols);
        int x;
        if (mode == 0) x = (k == 2) ? -5 : r*cols + c;
        else           x = ((r*131 + c*17 + k*53) % 2001) - 1000;
        return W'(x);
    endfunction

    function automatic logic [W-1:0] relu(input logic [W-1:0] x, input bit en);
        return (en && x[W-1]) ? '0 : x;
    endfunction

    function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input beat_t d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        conv_fin = 1'b0;
        reset    = 1'b0;
        idle(2);
        reset    = 1'b1;
        idle(1);
    endtask

    task automatic push_exp(input int a, input int b, input int c, input int idx);
        exp_t e;
        e.d[0] = W'(a);
        e.d[1] = W'(b);
        e.d[2] = W'(c);
        e.idx  = idx;
        e.cyc  = -1;
        sbq.push_back(e);
    endtask

    task automatic run_frame(input int rows, input int cols, input bit en, input int mode,
                             input bit use_model, input bit gaps, input bit fin_last);
        beat_t d;
        exp_t  e;
        row_len = 12'(cols);
        relu_en = en;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (gaps && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
                for (int k = 0; k < NOK; k++) d[k] = pixv(mode, k, r, c, cols);
                if (use_model && (r % 2 == 1) && (c % 2 == 1) && c < MAXW) begin
                    for (int k = 0; k < NOK; k++) begin
                        e.d[k] = smax(smax(relu(pixv(mode, k, r-1, c-1, cols), en),
                                           relu(pixv(mode, k, r-1, c,   cols), en)),
                                      smax(relu(pixv(mode, k, r,   c-1, cols), en),
                                           relu(pixv(mode, k, r,   c,   cols), en)));
                    end
                    e.idx = (r/2)*(cols/2) + (c/2);
                    e.cyc = cyc + 1;
                    sbq.push_back(e);
                end
                if (fin_last && r == rows-1 && c == cols-1) conv_fin = 1'b1;
                drive(d);
            end
        end
        if (fin_last) begin
            check("pool_fin_early", 64'(pool_fin), 64'd0);
            idle(1);
            check("pool_fin_rise", 64'(pool_fin), 64'd1);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && out_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: out_idx %0d out_data %h, required no pulse", out_idx, out_data);
                end else begin
                    e = sbq.pop_front();
                    check("out_data", 64'(out_data), 64'(e.d));
                    check("out_idx", 64'(out_idx), 64'(e.idx));
                    if (e.cyc >= 0) check("latency_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        in_data  = '0;
        in_valid = 1'b0;
        conv_fin = 1'b0;
        row_len  = 12'd4;
        relu_en  = 1'b1;
        reset    = 1'b0;
        idle(2);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_pool_fin", 64'(pool_fin), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        reset = 1'b1;
        idle(1);

        // 4x4, relu on: index ramp on ch0/ch1, constant -5 on ch2
        push_exp(5, 5, 0, 0);
        push_exp(7, 7, 0, 1);
        push_exp(13, 13, 0, 2);
        push_exp(15, 15, 0, 3);
        run_frame(4, 4, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("t1_pending", 64'(sbq.size()), 64'd0);
        check("t1_out_idx_end", 64'(out_idx), 64'd4);
        do_reset();

        // same stream, relu off: ch2 stays -5
        push_exp(5, 5, -5, 0);
        push_exp(7, 7, -5, 1);
        push_exp(13, 13, -5, 2);
        push_exp(15, 15, -5, 3);
        run_frame(4, 4, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("t2_pending", 64'(sbq.size()), 64'd0);
        do_reset();

        // 5x5: last column and last row dropped
        push_exp(6, 6, 0, 0);
        push_exp(8, 8, 0, 1);
        push_exp(16, 16, 0, 2);
        push_exp(18, 18, 0, 3);
        run_frame(5, 5, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("t3_pending", 64'(sbq.size()), 64'd0);
        check("t3_out_idx_end", 64'(out_idx), 64'd4);
        do_reset();

        // 28x28 signed mixed data with random gaps, relu off
        run_frame(28, 28, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        idle(2);
        check("t4_pending", 64'(sbq.size()), 64'd0);
        check("t4_out_idx_end", 64'(out_idx), 64'd196);
        do_reset();

        // 8x8 signed mixed data, relu on
        run_frame(8, 8, 1'b1, 1, 1'b1, 1'b0, 1'b1);
        idle(2);
        check("t4b_pending", 64'(sbq.size()), 64'd0);
        do_reset();

        // reset after 10 beats, then a full frame
        row_len = 12'd4;
        relu_en = 1'b1;
        push_exp(5, 5, 0, 0);
        push_exp(7, 7, 0, 1);
        for (int i = 0; i < 10; i++) begin
            beat_t d;
            for (int k = 0; k < NOK; k++) d[k] = pixv(0, k, i/4, i%4, 4);
            drive(d);
        end
        idle(2);
        check("t5_partial_pending", 64'(sbq.size()), 64'd0);
        do_reset();
        check("t5_idx_after_reset", 64'(out_idx), 64'd0);
        push_exp(5, 5, 0, 0);
        push_exp(7, 7, 0, 1);
        push_exp(13, 13, 0, 2);
        push_exp(15, 15, 0, 3);
        run_frame(4, 4, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("t5_pending", 64'(sbq.size()), 64'd0);
        do_reset();

        // conv_fin in IDLE with no beats; later beats ignored
        conv_fin = 1'b1;
        idle(1);
        check("t6_pool_fin_early", 64'(pool_fin), 64'd0);
        idle(1);
        check("t6_pool_fin", 64'(pool_fin), 64'd1);
        run_frame(4, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("t6_pool_fin_held", 64'(pool_fin), 64'd1);
        check("t6_out_idx", 64'(out_idx), 64'd0);
        do_reset();

        // row_len 1: no outputs, pool_fin still asserts
        run_frame(4, 1, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("t7_out_idx", 64'(out_idx), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
